// File: rtl/mdu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// sharing one accumulator; fixed latency for every op.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned AccW = 2 * XLEN + 1;
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN - 1){1'b0}}};

  mdu_state_e stateQ, stateD;
  mdu_op_e    opQ, opIn;
  logic [CntW-1:0] cntQ;
  logic [AccW-1:0] accQ, accNext;
  logic [XLEN-1:0] rs1Q, rs2Q, magBQ, resultQ, finalRes;
  logic            negAQ, negBQ, doneQ;

  // Operand preparation at acceptance
  logic            signedA, signedB, negAIn, negBIn;
  logic [XLEN-1:0] magAIn, magBIn;

  assign opIn    = mdu_op_e'(funct3);
  assign signedA = (opIn == MULH) || (opIn == MULHSU) || (opIn == DIV) || (opIn == REM);
  assign signedB = (opIn == MULH) || (opIn == DIV) || (opIn == REM);
  assign negAIn  = signedA && rs1Data[XLEN-1];
  assign negBIn  = signedB && rs2Data[XLEN-1];
  assign magAIn  = negAIn ? -rs1Data : rs1Data;
  assign magBIn  = negBIn ? -rs2Data : rs2Data;

  // One iteration of either datapath
  logic [XLEN:0]   mulSum, mulAdd, divTrial;
  logic [AccW-1:0] divShift;

  always_comb begin
    mulSum   = accQ[2*XLEN:XLEN] + {1'b0, magBQ};
    mulAdd   = accQ[0] ? mulSum : accQ[2*XLEN:XLEN];
    divShift = {accQ[2*XLEN-1:0], 1'b0};
    divTrial = divShift[2*XLEN:XLEN] - {1'b0, magBQ};
    if (opQ[2]) begin
      // Restore (keep shifted value) when the trial subtraction goes negative
      accNext = divTrial[XLEN] ? divShift : {divTrial, divShift[XLEN-1:1], 1'b1};
    end else begin
      accNext = {1'b0, mulAdd, accQ[XLEN-1:1]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (start) stateD = RUN;
      RUN:     if (cntQ == LastIter) stateD = FINISH;
      FINISH:  stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Outputs and final result selection
  logic [2*XLEN-1:0] prod, prodFix;
  logic [XLEN-1:0]   quo, quoFix, rem, remFix;
  logic              divByZero, overflow;

  always_comb begin
    busy      = (stateQ != IDLE);
    prod      = accQ[2*XLEN-1:0];
    prodFix   = (negAQ ^ negBQ) ? -prod : prod;
    quo       = accQ[XLEN-1:0];
    quoFix    = (negAQ ^ negBQ) ? -quo : quo;
    rem       = accQ[2*XLEN-1:XLEN];
    remFix    = negAQ ? -rem : rem;
    divByZero = (rs2Q == '0);
    overflow  = (rs1Q == MinInt) && (rs2Q == '1);
    finalRes  = '0;
    unique case (opQ)
      MUL:                 finalRes = prodFix[XLEN-1:0];
      MULH, MULHSU, MULHU: finalRes = prodFix[2*XLEN-1:XLEN];
      DIV, DIVU: begin
        if (divByZero)                      finalRes = '1;
        else if ((opQ == DIV) && overflow)  finalRes = rs1Q;
        else                                finalRes = quoFix;
      end
      REM, REMU: begin
        if (divByZero)                      finalRes = rs1Q;
        else if ((opQ == REM) && overflow)  finalRes = '0;
        else                                finalRes = remFix;
      end
      default: finalRes = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      opQ     <= MUL;
      cntQ    <= '0;
      accQ    <= '0;
      rs1Q    <= '0;
      rs2Q    <= '0;
      magBQ   <= '0;
      negAQ   <= 1'b0;
      negBQ   <= 1'b0;
      resultQ <= '0;
      doneQ   <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (stateQ)
        IDLE: begin
          if (start) begin
            opQ   <= opIn;
            cntQ  <= '0;
            accQ  <= {{(XLEN + 1){1'b0}}, magAIn};
            rs1Q  <= rs1Data;
            rs2Q  <= rs2Data;
            magBQ <= magBIn;
            negAQ <= negAIn;
            negBQ <= negBIn;
          end
        end
        RUN: begin
          accQ <= accNext;
          cntQ <= cntQ + 1'b1;
        end
        FINISH: begin
          resultQ <= finalRes;
          doneQ   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done   = doneQ;
  assign result = resultQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + scoreboard bench for mul_div_unit: results, latency, freezing, abort.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] expQ[$];

  mul_div_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1Data (rs1Data),
    .rs2Data (rs2Data),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference using native 64-bit / signed integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive one request; operands are scrambled right after acceptance
  task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    @(negedge clk);
    start   = 1'b1;
    funct3  = op;
    rs1Data = a;
    rs2Data = b;
    expQ.push_back(exp);
    @(negedge clk);
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1Data = $urandom;
    rs2Data = $urandom;
    cyc     = 0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic waitDone(input string tag);
    logic [31:0] exp;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    if (done === 1'b1) begin
      check({tag, "_latency"}, cyc, 32'd33);
      check({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
      check({tag, "_sb_nonempty"}, expQ.size(), 32'd1);
      exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
      check({tag, "_result"}, result, exp);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      check({tag, "_held"}, result, exp);
    end else begin
      expQ.delete();
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    startOp(op, a, b, exp);
    waitDone(tag);
  endtask

  initial begin
    int          dcount;
    logic [31:0] ra, rb;
    rst     = 1'b1;
    start   = 1'b0;
    funct3  = 3'd0;
    rs1Data = '0;
    rs2Data = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    runOp("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42);
    runOp("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    runOp("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("mulhsu_neg1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    runOp("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    runOp("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    runOp("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);
    runOp("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2);
    runOp("div_by_zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    runOp("remu_by_zero", 3'b111, 32'd5, 32'd0, 32'd5);
    runOp("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 6) ? 32'($urandom_range(1, 1000)) : $urandom;
      runOp("rand_op", 3'(i), ra, rb, model(3'(i), ra, rb));
    end

    // Start pulses and operand changes while busy must be ignored
    startOp(3'b000, 32'd3, 32'd4, 32'd12);
    repeat (5) begin @(negedge clk); cyc++; end
    start   = 1'b1;
    funct3  = 3'b000;
    rs1Data = 32'd9;
    rs2Data = 32'd9;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    waitDone("mul_ignore_start");
    runOp("mul_9x9", 3'b000, 32'd9, 32'd9, 32'd81);

    // Reset mid-operation aborts without a done pulse
    startOp(3'b101, 32'd1000, 32'd10, 32'd100);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    if (expQ.size() > 0) void'(expQ.pop_back());
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 32'd0);
    runOp("mul_after_abort", 3'b000, 32'd2, 32'd3, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
